// File: rtl/mdu_pkg.sv
// Shared definitions for the RV64M multi-cycle multiply/divide unit.
// Opcodes, sequencer states, iteration counts and a sign-extension helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIXUP,
    S_DONE
  } mdu_state_e;

  localparam int ITER_D = 64;
  localparam int ITER_W = 32;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shared 128-bit working register:
// shift-add multiply step or restoring trial-subtract divide step.
module mdu_iter_step
  import mdu_pkg::*;
(
  input  logic         is_div,
  input  logic [127:0] acc_i,
  input  logic [63:0]  opnd_i,
  output logic [127:0] acc_o
);

  logic [64:0] sum;
  logic [64:0] rem_sh;
  logic [64:0] diff;

  // mul: {hi,lo} = ({hi + lo[0]*mcand, lo}) >> 1; div: shift left, trial subtract
  always_comb begin
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    acc_o  = acc_i;
    if (is_div) begin
      rem_sh = {acc_i[127:64], acc_i[63]};
      diff   = rem_sh - {1'b0, opnd_i};
      if (!diff[64]) begin
        acc_o = {diff[63:0], acc_i[62:0], 1'b1};
      end else begin
        acc_o = {rem_sh[63:0], acc_i[62:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc_i[127:64]}
            + (acc_i[0] ? {1'b0, opnd_i} : 65'd0);
      acc_o = {sum, acc_i[63:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV64M multiply/divide sequencer with valid/ready and flush.
// MDU_FAST_MUL_EN selects a single-cycle combinational multiply.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [127:0]      acc_q, acc_d;
  logic [63:0]       opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic              neg1_q, neg1_d;
  logic              neg2_q, neg2_d;
  logic [63:0]       res_q, res_d;

  logic              sgn1, sgn2, n1, n2;
  logic              div0, ovf, is_div_in, is_rem_in;
  logic [63:0]       a_ext, b_ext, mag1, mag2, spec_res;
  logic [127:0]      step_acc, prod;
  logic [63:0]       quo, rem, fix;
  logic [CNT_W-1:0]  last_cnt;

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;
  assign last_cnt   = word_q ? CNT_W'(ITER_W - 1)
                             : CNT_W'(ITER_D - 1);

  mdu_iter_step u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Operand prep: width extension, magnitudes, special-case detection
  always_comb begin
    is_div_in = in_op[2];
    is_rem_in = in_op[2] & in_op[1];
    sgn1 = (in_op == OP_MUL) || (in_op == OP_MULH)
        || (in_op == OP_MULHSU) || (in_op == OP_DIV)
        || (in_op == OP_REM);
    sgn2 = (in_op == OP_MUL) || (in_op == OP_MULH)
        || (in_op == OP_DIV) || (in_op == OP_REM);
    a_ext = in_src1;
    b_ext = in_src2;
    if (in_word) begin
      a_ext = sgn1 ? sext32(in_src1[31:0]) : {32'b0, in_src1[31:0]};
      b_ext = sgn2 ? sext32(in_src2[31:0]) : {32'b0, in_src2[31:0]};
    end
    n1   = sgn1 & a_ext[63];
    n2   = sgn2 & b_ext[63];
    mag1 = n1 ? -a_ext : a_ext;
    mag2 = n2 ? -b_ext : b_ext;
    div0 = is_div_in && (b_ext == 64'd0);
    ovf  = is_div_in && sgn2 && (b_ext == '1)
        && (in_word ? (a_ext == 64'hFFFF_FFFF_8000_0000)
                    : (a_ext == 64'h8000_0000_0000_0000));
    spec_res = '0;
    if (div0) begin
      if (is_rem_in) begin
        spec_res = in_word ? sext32(in_src1[31:0]) : in_src1;
      end else begin
        spec_res = '1;
      end
    end else if (ovf) begin
      spec_res = is_rem_in ? 64'd0 : a_ext;
    end
  end

  // Sign fix-up and result selection from the working register
  always_comb begin
`ifdef MDU_FAST_MUL_EN
    prod = acc_q;
`else
    prod = word_q ? (acc_q >> 32) : acc_q;
`endif
    if (neg1_q ^ neg2_q) prod = -prod;
    quo = (neg1_q ^ neg2_q) ? -acc_q[63:0] : acc_q[63:0];
    rem = neg1_q ? -acc_q[127:64] : acc_q[127:64];
    if (op_q[2]) begin
      fix = op_q[1] ? rem : quo;
    end else begin
      fix = (op_q == OP_MUL) ? prod[63:0] : prod[127:64];
    end
    if (word_q) fix = sext32(fix[31:0]);
  end

  // Sequencer next-state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    word_d  = word_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          op_d   = in_op;
          word_d = in_word;
          neg1_d = n1;
          neg2_d = n2;
          opnd_d = mag2;
          cnt_d  = '0;
          if (is_div_in && in_word) begin
            acc_d = {64'b0, mag1[31:0], 32'b0};
          end else begin
            acc_d = {64'b0, mag1};
          end
          if (div0 || ovf) begin
            res_d   = spec_res;
            state_d = S_DONE;
          end else begin
            state_d = is_div_in ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
`ifdef MDU_FAST_MUL_EN
        acc_d   = {64'b0, acc_q[63:0]} * {64'b0, opnd_q};
        state_d = S_FIXUP;
`else
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last_cnt) state_d = S_FIXUP;
`endif
      end
      S_DIV: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last_cnt) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        res_d   = fix;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      word_q  <= word_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      res_q   <= res_d;
    end
  end

endmodule
